// File: rtl/mem_delayed.sv
// mem_delayed: word-addressed RAM model for the single-outstanding
// request/ack memory protocol, with a programmable access latency and a
// side-band load port for preloading images.
module mem_delayed #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd_req,
  input  logic        mem_wr_req,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] mem_rd_data,
  output logic        mem_ack,
  output logic        mem_busy,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic [31:0] mem [DEPTH];

  logic          req;
  logic          sample;
  logic          req_in_range;
  logic          load_in_range;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] load_idx;

  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic          inr_q;

  logic          fetch_rd;
  logic [AW-1:0] fetch_idx;
  logic          fetch_inr;

  logic          unused_bits;

  function automatic logic in_range(input logic [31:0] a);
    return {2'b00, a[31:2]} < 32'(DEPTH);
  endfunction

  assign req           = mem_rd_req | mem_wr_req;
  assign sample        = (state == IDLE) && req;
  assign req_in_range  = in_range(mem_addr);
  assign load_in_range = in_range(load_addr);
  assign req_idx       = mem_addr[AW+1:2];
  assign load_idx      = load_addr[AW+1:2];
  assign unused_bits   = ^{mem_addr[1:0], load_addr[1:0]};

  // Next-state, counter and read-fetch decisions for the access sequencer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fetch_rd  = 1'b0;
    fetch_idx = addr_q;
    fetch_inr = inr_q;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nxt = CNT_INIT;
          if (LATENCY > 1) begin
            state_nxt = WAIT;
          end else begin
            state_nxt = ACK;
            if (!mem_wr_req) begin
              fetch_rd  = 1'b1;
              fetch_idx = req_idx;
              fetch_inr = req_in_range;
            end
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          state_nxt = ACK;
          fetch_rd  = !wr_q;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and registered outputs; reset aborts any pending access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      mem_ack     <= 1'b0;
      mem_busy    <= 1'b0;
      mem_rd_data <= 32'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mem_ack  <= (state_nxt == ACK);
      mem_busy <= (state_nxt == WAIT);
      if (fetch_rd) begin
        mem_rd_data <= fetch_inr ? mem[fetch_idx] : 32'd0;
      end
    end
  end

  // Capture the word index, kind and range check of an accepted request.
  always_ff @(posedge clk) begin
    if (sample) begin
      addr_q <= req_idx;
      wr_q   <= mem_wr_req;
      inr_q  <= req_in_range;
    end
  end

  // Array writes: backdoor load first so a same-word protocol write wins.
  always_ff @(posedge clk) begin
    if (load_en && load_in_range) begin
      mem[load_idx] <= load_data;
    end
    if (!rst && sample && mem_wr_req && req_in_range) begin
      mem[req_idx] <= mem_wr_data;
    end
  end

endmodule

// File: tb/tb_mem_delayed.sv
// tb_mem_delayed: drives two mem_delayed instances (latency 4 and latency 1)
// with directed and randomized traffic and compares every cycle against a
// timestamp-based reference model of the protocol.
module tb_mem_delayed;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr    [2];
  logic        mem_rd_req  [2];
  logic        mem_wr_req  [2];
  logic [31:0] mem_wr_data [2];
  logic [31:0] mem_rd_data [2];
  logic        mem_ack     [2];
  logic        mem_busy    [2];
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  // Reference model state: array image, outstanding request timestamp.
  logic [31:0] ref_mem [2][DEPTH];
  bit          pend    [2];
  int          req_cyc [2];
  bit          p_wr    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] exp_rd  [2];
  logic [31:0] pre     [3];
  int          cyc;
  int          compared;
  int          mismatched;

  always #5 clk = ~clk;

  mem_delayed #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr[0]),
    .mem_rd_req  (mem_rd_req[0]),
    .mem_wr_req  (mem_wr_req[0]),
    .mem_wr_data (mem_wr_data[0]),
    .mem_rd_data (mem_rd_data[0]),
    .mem_ack     (mem_ack[0]),
    .mem_busy    (mem_busy[0]),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data)
  );

  mem_delayed #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr[1]),
    .mem_rd_req  (mem_rd_req[1]),
    .mem_wr_req  (mem_wr_req[1]),
    .mem_wr_data (mem_wr_data[1]),
    .mem_rd_data (mem_rd_data[1]),
    .mem_ack     (mem_ack[1]),
    .mem_busy    (mem_busy[1]),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data)
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a >> 2) < DEPTH;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Apply the effect of the edge that ends cycle 'cyc' to the model of DUT d.
  task automatic model_edge(input int d);
    int c    = cyc;
    bit took = 1'b0;
    if (rst) begin
      pend[d]   = 1'b0;
      exp_rd[d] = 32'd0;
    end else begin
      if ((!pend[d] || c > req_cyc[d] + lat_of(d)) && (mem_rd_req[d] || mem_wr_req[d])) begin
        pend[d]    = 1'b1;
        req_cyc[d] = c;
        p_wr[d]    = mem_wr_req[d];
        p_addr[d]  = mem_addr[d];
        took       = 1'b1;
      end
      if (pend[d] && !p_wr[d] && c == req_cyc[d] + lat_of(d) - 1) begin
        exp_rd[d] = in_range(p_addr[d]) ? ref_mem[d][p_addr[d][AW+1:2]] : 32'd0;
      end
    end
    if (load_en && in_range(load_addr)) begin
      ref_mem[d][load_addr[AW+1:2]] = load_data;
    end
    if (took && p_wr[d] && in_range(p_addr[d])) begin
      ref_mem[d][p_addr[d][AW+1:2]] = mem_wr_data[d];
    end
  endtask

  // One clock: update the model at the edge, then check both DUTs.
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) begin
      int   age;
      logic e_busy;
      logic e_ack;
      age    = cyc - req_cyc[d];
      e_busy = pend[d] && age >= 1 && age <= lat_of(d) - 1;
      e_ack  = pend[d] && age == lat_of(d);
      checkOutput($sformatf("dut%0d_busy", d), {31'b0, mem_busy[d]}, {31'b0, e_busy});
      checkOutput($sformatf("dut%0d_ack", d), {31'b0, mem_ack[d]}, {31'b0, e_ack});
      checkOutput($sformatf("dut%0d_rd_data", d), mem_rd_data[d], exp_rd[d]);
    end
  endtask

  task automatic applyStimulus(input int d, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    mem_rd_req[d]  = rd;
    mem_wr_req[d]  = wr;
    mem_addr[d]    = addr;
    mem_wr_data[d] = data;
    tick();
    mem_rd_req[d]  = 1'b0;
    mem_wr_req[d]  = 1'b0;
  endtask

  // Issue one request and stop in its ack cycle.
  task automatic access(input int d, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(d, rd, wr, addr, data);
    repeat (lat_of(d) - 1) tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    rst        = 1'b1;
    load_en    = 1'b0;
    load_addr  = 32'd0;
    load_data  = 32'd0;
    for (int d = 0; d < 2; d++) begin
      mem_addr[d]    = 32'd0;
      mem_rd_req[d]  = 1'b0;
      mem_wr_req[d]  = 1'b0;
      mem_wr_data[d] = 32'd0;
      pend[d]        = 1'b0;
      req_cyc[d]     = 0;
      p_wr[d]        = 1'b0;
      p_addr[d]      = 32'd0;
      exp_rd[d]      = 32'd0;
    end

    // Preload every word through the backdoor while reset is held.
    for (int w = 0; w < DEPTH; w++) begin
      load_en   = 1'b1;
      load_addr = 32'(w * 4);
      load_data = (w == 3) ? 32'hDEADBEEF : $urandom;
      if (w < 3) pre[w] = load_data;
      tick();
    end
    load_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Preload and read: busy for three cycles, then ack with the image.
    applyStimulus(0, 1'b1, 1'b0, 32'd12, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t1_busy", {31'b0, mem_busy[0]}, 32'd1);
      tick();
    end
    checkOutput("t1_ack", {31'b0, mem_ack[0]}, 32'd1);
    checkOutput("t1_data", mem_rd_data[0], 32'hDEADBEEF);
    tick();

    // Write then read back with misaligned low bits.
    access(0, 1'b0, 1'b1, 32'h40, 32'h12345678);
    checkOutput("t2_wr_ack", {31'b0, mem_ack[0]}, 32'd1);
    checkOutput("t2_wr_keeps_rd", mem_rd_data[0], 32'hDEADBEEF);
    tick();
    access(0, 1'b1, 1'b0, 32'h43, 32'd0);
    checkOutput("t2_readback", mem_rd_data[0], 32'h12345678);
    tick();

    // Stray read while busy is ignored.
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'd0);
    mem_rd_req[0] = 1'b1;
    mem_addr[0]   = 32'h100;
    tick();
    mem_rd_req[0] = 1'b0;
    tick();
    tick();
    checkOutput("t3_one_ack", {31'b0, mem_ack[0]}, 32'd1);
    checkOutput("t3_first_data", mem_rd_data[0], 32'h12345678);
    repeat (6) tick();

    // Simultaneous read and write acts as a write.
    access(0, 1'b1, 1'b1, 32'h80, 32'h000000A5);
    tick();
    access(0, 1'b1, 1'b0, 32'h80, 32'd0);
    checkOutput("t4_rdwr_is_write", mem_rd_data[0], 32'h000000A5);
    tick();

    // Out of range accesses.
    access(0, 1'b1, 1'b0, 32'(DEPTH * 4), 32'd0);
    checkOutput("t5_oor_ack", {31'b0, mem_ack[0]}, 32'd1);
    checkOutput("t5_oor_data", mem_rd_data[0], 32'd0);
    tick();
    access(0, 1'b0, 1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF);
    tick();
    access(0, 1'b1, 1'b0, 32'd0, 32'd0);
    checkOutput("t5_word0_intact", mem_rd_data[0], pre[0]);
    tick();

    // Latency-1 processor-style loop on the second instance.
    for (int i = 0; i < 3; i++) begin
      mem_rd_req[1] = 1'b1;
      mem_addr[1]   = 32'(i * 4);
      tick();
      mem_rd_req[1] = 1'b0;
      checkOutput("t6_ack", {31'b0, mem_ack[1]}, 32'd1);
      checkOutput("t6_busy", {31'b0, mem_busy[1]}, 32'd0);
      checkOutput("t6_data", mem_rd_data[1], pre[i]);
      tick();
    end

    // Reset in the middle of WAIT aborts the access.
    applyStimulus(0, 1'b1, 1'b0, 32'd12, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t7_rd_cleared", mem_rd_data[0], 32'd0);
    checkOutput("t7_no_ack", {31'b0, mem_ack[0]}, 32'd0);
    repeat (5) tick();
    access(0, 1'b1, 1'b0, 32'd12, 32'd0);
    checkOutput("t7_contents_kept", mem_rd_data[0], 32'hDEADBEEF);
    tick();

    // Randomized traffic, strays, backdoor collisions and occasional reset.
    for (int n = 0; n < 2000; n++) begin
      for (int d = 0; d < 2; d++) begin
        logic [29:0] w;
        w              = 30'($urandom_range(0, DEPTH + 3));
        mem_addr[d]    = {w, 2'($urandom_range(0, 3))};
        mem_rd_req[d]  = ($urandom_range(0, 2) == 0);
        mem_wr_req[d]  = ($urandom_range(0, 3) == 0);
        mem_wr_data[d] = $urandom;
      end
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = ($urandom_range(0, 3) == 0) ? mem_addr[$urandom_range(0, 1)]
                                              : {30'($urandom_range(0, DEPTH + 3)), 2'b00};
      load_data = $urandom;
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      mem_rd_req[d] = 1'b0;
      mem_wr_req[d] = 1'b0;
    end
    load_en = 1'b0;
    rst     = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
